// File: rtl/bcd_conv_arbiter_if.sv
// Request/grant/result bundle between two requesters and the shared BCD converter.
// Requester side (master) drives req0/val0/req1/val1 and watches the grant pulses.
// Converter side (slave) returns gnt0/gnt1, busy, done, owner and the held result digits.
interface bcd_conv_arbiter_if;
  logic       req0;
  logic [7:0] val0;
  logic       req1;
  logic [7:0] val1;
  logic       gnt0;
  logic       gnt1;
  logic       busy;
  logic       done;
  logic       owner;
  logic [3:0] centena;
  logic [3:0] dezena;
  logic [3:0] unidade;
  logic       negative;

  modport master (
    output req0, val0, req1, val1,
    input  gnt0, gnt1, busy, done, owner, centena, dezena, unidade, negative
  );

  modport slave (
    input  req0, val0, req1, val1,
    output gnt0, gnt1, busy, done, owner, centena, dezena, unidade, negative
  );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// Shared serial binary-to-BCD converter for two requesters (round-robin), sign + 3 digits.
// Latency: gnt the cycle after the request is sampled, done 8 cycles later; one result per 9 clocks.
// Backpressure: requests are only sampled in IDLE; requesters hold req until their gnt pulse.
// Ports: clock, reset (async, active-high), bus (slave modport: req/val in, gnt/busy/done/result out).
module bcd_conv_arbiter (
  input  logic              clock,
  input  logic              reset,
  bcd_conv_arbiter_if.slave bus
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state;
  logic [7:0] mag;        // captured magnitude, 0..128
  logic       sign;       // captured sign of the value in flight
  logic       idx;        // requester that owns the value in flight
  logic [2:0] cnt;        // index of the magnitude bit shifted in next
  logic [3:0] hun;        // working digits, kept apart from the result registers
  logic [3:0] ten;
  logic [3:0] uni;
  logic       prio;       // requester that wins a tie

  // Double-dabble correction: a digit >= 5 would overflow past 9 once doubled.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  logic [3:0] hun_adj, ten_adj, uni_adj;
  logic [3:0] hun_nxt, ten_nxt, uni_nxt;

  always_comb begin
    hun_adj = add3(hun);
    ten_adj = add3(ten);
    uni_adj = add3(uni);
    hun_nxt = {hun_adj[2:0], ten_adj[3]};
    ten_nxt = {ten_adj[2:0], uni_adj[3]};
    uni_nxt = {uni_adj[2:0], mag[cnt]};
  end

  // Round-robin pick: a lone requester always wins, a tie goes to prio.
  logic       sel;
  logic [7:0] sel_val;

  always_comb begin
    sel     = (bus.req0 && bus.req1) ? prio : bus.req1;
    sel_val = sel ? bus.val1 : bus.val0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      mag          <= 8'd0;
      sign         <= 1'b0;
      idx          <= 1'b0;
      cnt          <= 3'd0;
      hun          <= 4'd0;
      ten          <= 4'd0;
      uni          <= 4'd0;
      prio         <= 1'b0;
      bus.gnt0     <= 1'b0;
      bus.gnt1     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.owner    <= 1'b0;
      bus.centena  <= 4'd0;
      bus.dezena   <= 4'd0;
      bus.unidade  <= 4'd0;
      bus.negative <= 1'b0;
    end else begin
      bus.gnt0 <= 1'b0;
      bus.gnt1 <= 1'b0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            // 8'h80 negates to itself, which reads correctly as unsigned 128.
            mag      <= sel_val[7] ? (~sel_val + 8'd1) : sel_val;
            sign     <= sel_val[7];
            idx      <= sel;
            hun      <= 4'd0;
            ten      <= 4'd0;
            uni      <= 4'd0;
            cnt      <= 3'd7;
            prio     <= ~sel;
            bus.gnt0 <= ~sel;
            bus.gnt1 <= sel;
            bus.busy <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          hun <= hun_nxt;
          ten <= ten_nxt;
          uni <= uni_nxt;
          cnt <= cnt - 3'd1;
          if (cnt == 3'd0) begin
            // Last bit: publish the freshly shifted digits directly.
            bus.centena  <= hun_nxt;
            bus.dezena   <= ten_nxt;
            bus.unidade  <= uni_nxt;
            bus.negative <= sign;
            bus.owner    <= idx;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter: reset, single conversions, sign extremes,
// round-robin contention, mid-conversion reset and result stability while busy.
module tb_bcd_conv_arbiter;
  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bcd_conv_arbiter_if bus();

  bcd_conv_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] actv, input logic [31:0] expv);
    checks++;
    if (actv !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actv, expv);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"}, {bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.owner, bus.negative}, 0);
    check({tag, "_dig"}, {bus.centena, bus.dezena, bus.unidade}, 0);
  endtask

  // Waits (bounded) for done; n = cycles waited, bc = busy cycles seen on the way.
  task automatic wait_done(output int n, output int bc);
    n  = 0;
    bc = bus.busy ? 1 : 0;
    while (!bus.done && n < 20) begin
      tick;
      n++;
      if (bus.busy) bc++;
    end
  endtask

  task automatic conv(input logic r, input logic [7:0] v, input logic [11:0] digs,
                      input logic neg, input string tag);
    int n, bc;
    if (r) begin bus.req1 = 1'b1; bus.val1 = v; end
    else   begin bus.req0 = 1'b1; bus.val0 = v; end
    tick;
    check({tag, "_gnt"}, {bus.gnt1, bus.gnt0}, r ? 2'b10 : 2'b01);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_done(n, bc);
    check({tag, "_lat"}, n, 8);
    check({tag, "_busy"}, bc, 8);
    check({tag, "_dig"}, {bus.centena, bus.dezena, bus.unidade}, digs);
    check({tag, "_own_neg"}, {bus.owner, bus.negative}, {r, neg});
    tick;
    check({tag, "_done_pulse"}, bus.done, 0);
  endtask

  initial begin
    int n, bc, ndone, bad_g, bad_o;
    bus.req0 = 1'b0; bus.val0 = 8'd0;
    bus.req1 = 1'b0; bus.val1 = 8'd0;
    reset = 1'b1;
    #2;
    check_zero("rst_init");
    @(negedge clock) reset = 1'b0;
    tick; tick;
    check_zero("rst_idle");

    conv(1'b0, 8'h7F, 12'h127, 1'b0, "pos127");
    conv(1'b1, 8'h80, 12'h128, 1'b1, "neg128");
    conv(1'b1, 8'hFF, 12'h001, 1'b1, "neg1");

    // Asynchronous reset between edges clears the held result at once.
    #2 reset = 1'b1;
    #1 check_zero("rst_async");
    @(negedge clock) reset = 1'b0;

    // Contention: both held high throughout.
    bus.req0 = 1'b1; bus.val0 = 8'hC8;
    bus.req1 = 1'b1; bus.val1 = 8'd42;
    tick;
    check("cont_g0", {bus.gnt1, bus.gnt0}, 2'b01);
    wait_done(n, bc);
    check("cont_lat0", n, 8);
    check("cont_dig0", {bus.centena, bus.dezena, bus.unidade}, 12'h056);
    check("cont_own0", {bus.owner, bus.negative}, 2'b01);
    tick;
    check("cont_g1", {bus.gnt1, bus.gnt0}, 2'b10);
    wait_done(n, bc);
    check("cont_lat1", n, 8);
    check("cont_dig1", {bus.centena, bus.dezena, bus.unidade}, 12'h042);
    check("cont_own1", {bus.owner, bus.negative}, 2'b10);
    tick;
    check("cont_g0b", {bus.gnt1, bus.gnt0}, 2'b01);
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_done(n, bc);
    check("cont_dig2", {bus.centena, bus.dezena, bus.unidade}, 12'h056);
    tick;

    // Reset during cycle 4 of a conversion of 99.
    bus.req0 = 1'b1; bus.val0 = 8'd99;
    tick;
    check("mid_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
    bus.req0 = 1'b0;
    tick; tick; tick;
    #2 reset = 1'b1;
    #1 check_zero("rst_mid");
    @(negedge clock) reset = 1'b0;
    ndone = 0;
    repeat (12) begin
      tick;
      if (bus.done) ndone++;
    end
    check("rst_nodone", ndone, 0);
    conv(1'b1, 8'd5, 12'h005, 1'b0, "post_rst");

    // Stability: inputs churn while busy; previous result (0,0,5 owner 1) must hold.
    bus.req0 = 1'b1; bus.val0 = 8'd10;
    tick;
    check("stab_gnt", {bus.gnt1, bus.gnt0}, 2'b01);
    bus.req0 = 1'b0;
    bad_g = 0;
    bad_o = 0;
    for (int i = 1; i <= 7; i++) begin
      bus.val0 = 8'($urandom);
      bus.req1 = i[0];
      tick;
      if (bus.gnt0 || bus.gnt1) bad_g++;
      if ({bus.centena, bus.dezena, bus.unidade, bus.negative, bus.owner} != {12'h005, 1'b0, 1'b1})
        bad_o++;
    end
    bus.req1 = 1'b0;
    tick;
    check("stab_spurious_gnt", bad_g, 0);
    check("stab_hold", bad_o, 0);
    check("stab_done", bus.done, 1);
    check("stab_dig", {bus.centena, bus.dezena, bus.unidade}, 12'h010);
    check("stab_own_neg", {bus.owner, bus.negative}, 2'b00);
    tick;
    check("stab_idle", {bus.gnt1, bus.gnt0, bus.busy}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
